mips32_fetch_stage: RTL and testbench
=====================================

// Module: mips32_fetch_stage
// PURPOSE
// - Instruction-fetch front end of the pipelined MIPS32 core: owns the PC and issues word reads to instruction memory.
// - Buffers returned words in a small queue and presents {IR, NPC} to the ID stage over a valid/ready handshake.
// - Sits between instruction memory and ID, and absorbs ID back-pressure.
// - Handles EX branch redirects and stops fetching at HLT.
// PARAMETERS
// - RESET_PC   32'd0   PC value loaded on reset (word address; PC steps by 1)
// - DEPTH      2       instruction queue entries (>=2 for 1 instr/cycle throughput)
// - HLT_OP     6'h3f   opcode in IR[31:26] that halts fetch
// PORTS
// - clk1            in   1   single clock; all state updates on rising edge
// - rst             in   1   reset, synchronous, active-high
// - imem_req        out  1   read request this cycle
// - imem_addr       out  32  word address of the request (= PC)
// - imem_rdata      in   32  read data; fixed latency, valid exactly 1 cycle after imem_req
// - redirect_valid  in   1   taken branch from EX; one-cycle pulse
// - redirect_pc     in   32  branch target
// - if_valid        out  1   queue head valid toward ID
// - if_ready        in   1   ID accepts head; transfer = if_valid & if_ready
// - if_ir           out  32  head instruction word
// - if_npc          out  32  head address + 1
// - halted          out  1   HLT has been consumed by ID; fetch stopped
// BEHAVIOUR
// - Reset, synchronous: PC<=RESET_PC, queue empty, no response in flight, state RUN.
//   Outputs after reset: if_valid=0, halted=0, imem_req=0 during the reset cycle.
// - Issue rule: imem_req=1 in RUN when (occupancy + inflight - pop) < DEPTH. On issue, PC<=PC+1 (32-bit wrap).
// - Response handling: the response is written into the queue at the end of the cycle it returns.
//   Latency: req in cycle N -> if_valid in cycle N+2.
//   Queue entry = {rdata, addr+1}. Steady state: one word per cycle.
// - Queue: FIFO, order preserved.
//   Simultaneous push and pop when full: allowed (the credit rule guarantees no overflow).
//   A pop from an empty queue cannot occur (if_valid=0).
//   Head outputs hold stable while if_valid & !if_ready.
// - Redirect (highest priority), in the cycle redirect_valid=1:
//   - PC<=redirect_pc.
//   - Queue flushed; if_valid=0 next cycle.
//   - A response returning next cycle is discarded (drop flag).
//   - No request issues in the redirect cycle; fetch from redirect_pc starts the cycle after.
// - HLT detection: a response whose IR[31:26]==HLT_OP is queued normally.
// - FSM states:
//   - RUN -> HALT_PEND when an HLT word is pushed. In HALT_PEND, no further requests issue.
//   - HALT_PEND -> RUN on redirect (HLT was wrong-path; flush as above).
//   - HALT_PEND -> HALTED when the HLT word transfers to ID.
//   - HALTED: imem_req=0, if_valid=0, halted=1, redirect ignored. Only rst exits.
// - Simultaneous redirect and HLT pop in the same cycle: the redirect wins, the pop is discarded, state RUN.
// - Reset mid-operation: state cleared the same edge. A response returning after reset is dropped.
// STRUCTURE
// - Shared package mips32_pkg holds:
//   - opcode constants: ADD 6'h00, SUB 6'h01, AND 6'h02, OR 6'h03, SLT 6'h04, MUL 6'h05, HLT 6'h3f,
//     LW 6'h08, SW 6'h09, ADDI 6'h0a, SUBI 6'h0b, SLTI 6'h0c, BNEQZ 6'h0d, BEQZ 6'h0e;
//   - WORD_W=32;
//   - fetch_state_t enum {RUN, HALT_PEND, HALTED}.
// - One sub-module: mips32_inst_fifo, a DEPTH-entry 64-bit synchronous FIFO with flush, count, push/pop.
// - The top level holds the PC, credit/issue logic, drop flag and FSM.
// TESTING
// - Straight-line fetch: memory model with 1-cycle latency; Mem[0..2]=2801000a,28020014,28030019; if_ready=1.
//   -> imem_addr 0,1,2 on consecutive cycles.
//   -> if_valid first high at cycle 2 with if_ir=2801000a, if_npc=1; one instruction per cycle after that.
// - Back-pressure: if_ready=0 for 6 cycles after the first if_valid.
//   -> imem_req drops once occupancy+inflight=DEPTH; head stays 2801000a.
//   -> On release, the sequence continues with no loss or duplication.
// - Redirect with a response in flight: redirect_valid=1, redirect_pc=8, while addr 3 is outstanding.
//   -> In-flight and queued words dropped; next imem_addr=8.
//   -> The next transferred if_ir=Mem[8], if_npc=9.
// - Halt: Mem[8]=fc000000.
//   -> No request after addr 8.
//   -> HLT transfers to ID, then halted=1 next cycle; imem_req stays 0.
//   -> A later redirect_valid is ignored.
// - Wrong-path HLT: HLT queued (HALT_PEND), then redirect to pc=3 before the pop.
//   -> halted stays 0; fetch resumes at addr 3.
// - Reset mid-stream: rst=1 for 1 cycle while the queue is full and if_ready=0.
//   -> if_valid=0 next cycle; the next imem_addr is RESET_PC; the stale response is not queued.

Source files
------------

// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcode constants, datapath width and fetch FSM states.
package mips32_pkg;

  localparam int WORD_W = 32;

  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_SLT   = 6'h04;
  localparam logic [5:0] OP_MUL   = 6'h05;
  localparam logic [5:0] OP_HLT   = 6'h3f;
  localparam logic [5:0] OP_LW    = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0a;
  localparam logic [5:0] OP_SUBI  = 6'h0b;
  localparam logic [5:0] OP_SLTI  = 6'h0c;
  localparam logic [5:0] OP_BNEQZ = 6'h0d;
  localparam logic [5:0] OP_BEQZ  = 6'h0e;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_PEND = 2'd1,
    HALTED    = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/mips32_inst_fifo.sv
// Small first-word-fall-through FIFO holding fetched {IR, NPC} pairs.
// Flush empties it in one cycle; push and pop may coincide even when full.
module mips32_inst_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;
  logic [PTR_W-1:0] wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_next;

  assign wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + 1'b1;
  assign rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + 1'b1;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_next;
      if (pop)  rd_ptr_reg <= rd_ptr_next;
      count_reg <= count_next;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk1) begin
    if (push && !flush && !rst) mem_reg[wr_ptr_reg] <= push_data;
  end

  assign head  = mem_reg[rd_ptr_reg];
  assign empty = (count_reg == '0);
  assign count = count_reg;

endmodule

// File: rtl/mips32_fetch_stage.sv
// MIPS32 instruction fetch: PC, credit-based issue to a 1-cycle instruction memory,
// instruction queue toward ID, branch redirect flush and HLT stop.
module mips32_fetch_stage
  import mips32_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC = 32'd0,
  parameter int                DEPTH    = 2,
  parameter logic [5:0]        HLT_OP   = 6'h3f
) (
  input  logic              clk1,
  input  logic              rst,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [WORD_W-1:0] if_ir,
  output logic [WORD_W-1:0] if_npc,
  output logic              halted
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_state_t      state_reg;
  fetch_state_t      state_next;
  logic [WORD_W-1:0] pc_reg;
  logic [WORD_W-1:0] req_addr_reg;
  logic              inflight_reg;
  logic              drop_reg;

  logic                  redirect_take;
  logic                  resp_valid;
  logic                  resp_hlt;
  logic                  pop_raw;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic [2*WORD_W-1:0]   fifo_head;
  logic [CNT_W:0]        occ_sum;

  // Once halted, the core is frozen until reset, so redirects are ignored.
  assign redirect_take = redirect_valid && (state_reg != HALTED);
  assign resp_valid    = inflight_reg && !drop_reg;
  assign resp_hlt      = resp_valid && (imem_rdata[31:26] == HLT_OP);

  assign if_valid = !fifo_empty && (state_reg != HALTED);
  assign if_ir    = fifo_head[2*WORD_W-1:WORD_W];
  assign if_npc   = fifo_head[WORD_W-1:0];
  assign halted   = (state_reg == HALTED);

  assign pop_raw   = if_valid && if_ready;
  assign fifo_pop  = pop_raw && !redirect_take;
  assign fifo_push = resp_valid && !redirect_take;

  // Slots already spoken for at the end of this cycle: queued + returning - leaving.
  assign occ_sum = {1'b0, fifo_count} + {{CNT_W{1'b0}}, resp_valid} - {{CNT_W{1'b0}}, pop_raw};

  // An HLT word returning this cycle already blocks the request behind it.
  assign imem_req  = !rst && (state_reg == RUN) && !redirect_take && !resp_hlt &&
                     (occ_sum < (CNT_W + 1)'(DEPTH));
  assign imem_addr = pc_reg;

  mips32_inst_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2 * WORD_W),
    .CNT_W (CNT_W)
  ) u_inst_fifo (
    .clk1      (clk1),
    .rst       (rst),
    .flush     (redirect_take),
    .push      (fifo_push),
    .push_data ({imem_rdata, req_addr_reg + 32'd1}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        if (!redirect_take && resp_hlt) state_next = HALT_PEND;
      end
      HALT_PEND: begin
        if (redirect_take) state_next = RUN;
        else if (pop_raw && (if_ir[31:26] == HLT_OP)) state_next = HALTED;
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      state_reg    <= RUN;
      pc_reg       <= RESET_PC;
      req_addr_reg <= '0;
      inflight_reg <= 1'b0;
      drop_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      inflight_reg <= imem_req;
      drop_reg     <= redirect_take;
      if (imem_req) req_addr_reg <= pc_reg;
      if (redirect_take) pc_reg <= redirect_pc;
      else if (imem_req) pc_reg <= pc_reg + 32'd1;
    end
  end

endmodule

// File: tb/tb_mips32_fetch_stage.sv
// Bench for mips32_fetch_stage: directed scenarios with literal expectations plus a
// randomized run checked every cycle against a program-order fetch model.
module tb_mips32_fetch_stage;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'd0;
  localparam logic [5:0]  HLT      = 6'h3f;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_ir;
  logic [31:0] if_npc;
  logic        halted;

  always #5 clk1 = ~clk1;

  mips32_fetch_stage dut (
    .clk1           (clk1),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_ir          (if_ir),
    .if_npc         (if_npc),
    .halted         (halted)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] mem_arr [64];
  logic [5:0]  ops [13];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (a < 32'd64) return mem_arr[a[5:0]];
    return {6'h0a, a[25:0]};
  endfunction

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model + compare process ----------------
  bit          m_halted = 0, hlt_req = 0, expect_empty = 0, stall_prev = 0, pop = 0;
  logic [31:0] exp_req = RESET_PC, exp_pop = RESET_PC, stall_ir, stall_npc, w;
  int          outstanding = 0, idle = 0;

  always @(negedge clk1) begin
    if (stall_prev) begin
      chk(if_valid == 1'b1, "stall_valid", 32'(if_valid), 32'd1);
      chk(if_ir == stall_ir, "stall_ir", if_ir, stall_ir);
      chk(if_npc == stall_npc, "stall_npc", if_npc, stall_npc);
    end
    stall_prev = 0;
    if (rst) begin
      chk(!imem_req, "req_in_reset", 32'(imem_req), 32'd0);
      m_halted = 0; hlt_req = 0; exp_req = RESET_PC; exp_pop = RESET_PC;
      outstanding = 0; expect_empty = 1; idle = 0;
    end else if (m_halted) begin
      chk(halted, "halted", 32'(halted), 32'd1);
      chk(!imem_req, "req_when_halted", 32'(imem_req), 32'd0);
      chk(!if_valid, "valid_when_halted", 32'(if_valid), 32'd0);
    end else begin
      chk(!halted, "not_halted", 32'(halted), 32'd0);
      if (expect_empty) chk(!if_valid, "empty_after_flush", 32'(if_valid), 32'd0);
      expect_empty = 0;
      if (redirect_valid) begin
        chk(!imem_req, "req_on_redirect", 32'(imem_req), 32'd0);
        exp_req = redirect_pc; exp_pop = redirect_pc;
        outstanding = 0; hlt_req = 0; expect_empty = 1; idle = 0;
      end else begin
        pop = if_valid && if_ready;
        if (imem_req) begin
          chk(!hlt_req, "req_after_hlt", 32'(imem_req), 32'd0);
          chk(imem_addr == exp_req, "imem_addr", imem_addr, exp_req);
          chk(outstanding - int'(pop) + 1 <= DEPTH, "credit", 32'(outstanding), 32'(DEPTH));
          outstanding++;
          w = mem_rd(exp_req);
          if (w[31:26] == HLT) hlt_req = 1;
          exp_req = exp_req + 32'd1;
        end
        if (pop) begin
          w = mem_rd(exp_pop);
          chk(if_ir == w, "if_ir", if_ir, w);
          chk(if_npc == exp_pop + 32'd1, "if_npc", if_npc, exp_pop + 32'd1);
          outstanding--;
          if (w[31:26] == HLT) m_halted = 1;
          exp_pop = exp_pop + 32'd1;
          idle = 0;
        end else if (if_ready) begin
          idle++;
          chk(idle <= 8, "liveness", 32'(idle), 32'd8);
          if (idle > 8) idle = 0;
        end
        if (if_valid && !if_ready) begin
          stall_prev = 1; stall_ir = if_ir; stall_npc = if_npc;
        end
      end
    end
  end

  // ---------------- stimulus + instruction memory ----------------
  bit          pend = 0;
  logic [31:0] pend_addr = '0;

  task automatic step(input bit r, input bit rdy, input bit rv, input logic [31:0] rpc);
    @(posedge clk1);
    #1;
    imem_rdata     = pend ? mem_rd(pend_addr) : 32'hdeadbeef;
    rst            = r;
    if_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    @(negedge clk1);
    pend      = imem_req;
    pend_addr = imem_addr;
  endtask

  task automatic load_directed();
    mem_arr[0] = 32'h2801000a;
    mem_arr[1] = 32'h28020014;
    mem_arr[2] = 32'h28030019;
    for (int i = 3; i < 8; i++) mem_arr[i] = 32'h28040000 + 32'(i);
    mem_arr[8] = 32'hfc000000;
    for (int i = 9; i < 64; i++) mem_arr[i] = 32'h28050000 + 32'(i);
  endtask

  task automatic load_random();
    logic [5:0] op;
    for (int i = 0; i < 64; i++) begin
      op = ($urandom_range(0, 15) == 0) ? HLT : ops[$urandom_range(0, 12)];
      mem_arr[i] = {op, 26'($urandom)};
    end
  endtask

  int halt_cnt;
  bit r, rdy, rv;
  logic [31:0] rpc;

  initial begin
    ops = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e};
    rst = 1'b1; if_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; imem_rdata = '0;
    load_directed();

    // Straight-line fetch, redirect with addr 3 outstanding, then HLT.
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    chk(imem_req && imem_addr == 32'd0, "sl_addr0", imem_addr, 32'd0);
    chk(!if_valid, "sl_valid_c0", 32'(if_valid), 32'd0);
    step(0, 1, 0, 0);
    chk(imem_req && imem_addr == 32'd1, "sl_addr1", imem_addr, 32'd1);
    chk(!if_valid, "sl_valid_c1", 32'(if_valid), 32'd0);
    step(0, 1, 0, 0);
    chk(imem_req && imem_addr == 32'd2, "sl_addr2", imem_addr, 32'd2);
    chk(if_valid && if_ir == 32'h2801000a, "sl_ir_c2", if_ir, 32'h2801000a);
    chk(if_npc == 32'd1, "sl_npc_c2", if_npc, 32'd1);
    step(0, 1, 0, 0);
    chk(if_valid && if_ir == 32'h28020014, "sl_ir_c3", if_ir, 32'h28020014);
    chk(imem_req && imem_addr == 32'd3, "sl_addr3", imem_addr, 32'd3);
    step(0, 1, 1, 32'd8);
    step(0, 1, 0, 0);
    chk(imem_req && imem_addr == 32'd8, "rd_addr8", imem_addr, 32'd8);
    step(0, 1, 0, 0);
    chk(!imem_req, "hlt_no_req", 32'(imem_req), 32'd0);
    step(0, 1, 0, 0);
    chk(if_valid && if_ir == 32'hfc000000, "rd_ir_hlt", if_ir, 32'hfc000000);
    chk(if_npc == 32'd9, "rd_npc9", if_npc, 32'd9);
    step(0, 1, 0, 0);
    chk(halted, "halted_after_hlt", 32'(halted), 32'd1);
    step(0, 1, 1, 32'd0);
    step(0, 1, 0, 0);
    chk(halted && !imem_req, "redirect_ignored", 32'(imem_req), 32'd0);

    // Back-pressure for 6 cycles from the first if_valid, then reset mid-stream.
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, 0);
      chk(if_valid && if_ir == 32'h2801000a, "bp_head", if_ir, 32'h2801000a);
      chk(!imem_req, "bp_no_req", 32'(imem_req), 32'd0);
    end
    step(0, 1, 0, 0);
    chk(imem_req && imem_addr == 32'd2, "bp_resume_addr", imem_addr, 32'd2);
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk(!if_valid, "rst_valid_clear", 32'(if_valid), 32'd0);
    chk(imem_req && imem_addr == RESET_PC, "rst_addr", imem_addr, RESET_PC);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk(if_valid && if_ir == 32'h2801000a, "rst_first_ir", if_ir, 32'h2801000a);

    // Wrong-path HLT: queued while stalled, then redirected away.
    step(1, 0, 0, 0);
    mem_arr[1] = 32'hfc000000;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk(!imem_req, "wp_pend_no_req", 32'(imem_req), 32'd0);
    step(0, 0, 1, 32'd3);
    step(0, 1, 0, 0);
    chk(imem_req && imem_addr == 32'd3, "wp_resume_addr3", imem_addr, 32'd3);
    chk(!halted, "wp_not_halted", 32'(halted), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0);

    // Randomized run.
    step(1, 0, 0, 0);
    load_random();
    halt_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      r   = ($urandom_range(0, 299) == 0) || (halt_cnt >= 4);
      rdy = ($urandom_range(0, 9) < 7);
      rv  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hfffffffc + 32'($urandom_range(0, 3))
                                         : 32'($urandom_range(0, 63));
      step(r, rdy, rv, rpc);
      if (r) begin
        load_random();
        halt_cnt = 0;
      end else if (halted) begin
        halt_cnt++;
      end
    end
    step(0, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
